// File: rtl/bus_regfile_pkg.sv
// Shared types and bus source codes for the register bank and bus-select encoder.
// Source codes 0-15 are R0-R15; 16-31 are external sources (24-31 reserved).
package bus_regfile_pkg;

    localparam int WIDTH = 32;
    localparam int NREGS = 16;
    localparam int NSRC  = 32;
    localparam int SEL_W = 5;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SRC_R0     = 5'd0;
    localparam sel_t SRC_R15    = 5'd15;
    localparam sel_t SRC_HI     = 5'd16;
    localparam sel_t SRC_LO     = 5'd17;
    localparam sel_t SRC_ZHI    = 5'd18;
    localparam sel_t SRC_ZLO    = 5'd19;
    localparam sel_t SRC_PC     = 5'd20;
    localparam sel_t SRC_MDR    = 5'd21;
    localparam sel_t SRC_INPORT = 5'd22;
    localparam sel_t SRC_C      = 5'd23;

endpackage

// File: rtl/bus_regfile_if.sv
// Bus-side signal bundle between the control unit / bus mux and bus_regfile.
interface bus_regfile_if;
    import bus_regfile_pkg::*;

    logic [WIDTH-1:0]       bus_in;
    logic [NREGS-1:0]       reg_in;
    logic [NREGS-1:0]       reg_out;
    logic [15:0]            ext_out;
    logic                   ba_out;
    logic [NREGS*WIDTH-1:0] regs_flat;
    sel_t                   bus_sel;
    logic                   src_valid;
    logic                   src_conflict;

    modport master (
        output bus_in, reg_in, reg_out, ext_out, ba_out,
        input  regs_flat, bus_sel, src_valid, src_conflict
    );

    modport slave (
        input  bus_in, reg_in, reg_out, ext_out, ba_out,
        output regs_flat, bus_sel, src_valid, src_conflict
    );
endinterface

// File: rtl/bus_regfile_encoder32.sv
// Combinational 32-to-5 lowest-index priority encoder with any/multi flags.
module bus_encoder32
    import bus_regfile_pkg::*;
(
    input  logic [NSRC-1:0] req,
    output sel_t            sel,
    output logic            any,
    output logic            multi
);

    always_comb begin
        sel = '0;
        // Scan from the top so the lowest set index wins.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) sel = SEL_W'(i);
        end
    end

    assign any   = |req;
    assign multi = |(req & (req - NSRC'(1)));

endmodule

// File: rtl/bus_regfile.sv
// R0-R15 register bank plus registered bus-mux select with sticky conflict flag.
// Optional macro BUS_R0_ZERO_EN: registered ba_out forces the R0 slice of regs_flat to zero.
module bus_regfile
    import bus_regfile_pkg::*;
(
    input  logic          clock,
    input  logic          clear_n,
    bus_regfile_if.slave  bus
);

    word_t            regs [NREGS];
    logic [NSRC-1:0]  req;
    sel_t             enc_sel;
    logic             enc_any;
    logic             enc_multi;
    sel_t             sel_q;
    logic             valid_q;
    logic             conflict_q;

    assign req = {bus.ext_out, bus.reg_out};

    bus_encoder32 u_enc (
        .req   (req),
        .sel   (enc_sel),
        .any   (enc_any),
        .multi (enc_multi)
    );

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            for (int n = 0; n < NREGS; n++) regs[n] <= '0;
        end else begin
            for (int n = 0; n < NREGS; n++) begin
                if (bus.reg_in[n]) regs[n] <= bus.bus_in;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            sel_q      <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            valid_q <= enc_any;
            if (enc_any) sel_q <= enc_sel;
            if (enc_multi) conflict_q <= 1'b1;
        end
    end

    assign bus.bus_sel      = sel_q;
    assign bus.src_valid    = valid_q;
    assign bus.src_conflict = conflict_q;

`ifdef BUS_R0_ZERO_EN
    logic ba_q;

    always_ff @(posedge clock) begin
        if (!clear_n) ba_q <= 1'b0;
        else          ba_q <= bus.ba_out;
    end

    assign bus.regs_flat[0 +: WIDTH] = ba_q ? '0 : regs[0];
`else
    logic unused_ba;
    assign unused_ba = bus.ba_out;

    assign bus.regs_flat[0 +: WIDTH] = regs[0];
`endif

    for (genvar g = 1; g < NREGS; g++) begin : g_flat
        assign bus.regs_flat[g*WIDTH +: WIDTH] = regs[g];
    end

endmodule

// File: doc/bus_regfile.md
# bus_regfile

General-purpose register bank and bus-source encoder sitting directly upstream of the 32:1 bus multiplexer array. Holds R0–R15, captures the bus on one-hot load enables, and turns the 32 one-hot "out" enables (R0–R15 plus 16 external sources) into the registered 5-bit select that drives every bit-slice of the bus mux. Flags illegal multi-source cycles with a sticky error.

## Interface
- WIDTH, 32, datapath width (bus and register width)
- NREGS, 16, number of general-purpose registers (fixed at 16; occupies bus source codes 0–15)

- clock  in  1  single clock; all state updates on rising edge
- clear_n  in  1  reset, synchronous and active-low
- bus_in  in  WIDTH  current bus value (output of the bus mux array)
- reg_in  in  NREGS  one-hot-or-multi load enables; bit n loads Rn from bus_in
- reg_out  in  NREGS  out enables for R0–R15 (source codes 0–15)
- ext_out  in  16  out enables for external sources (HI, LO, Zhigh, Zlow, PC, MDR, InPort, C… ; codes 16–31)
- ba_out  in  1  base-address out qualifier for R0 (see Configuration)
- regs_flat  out  NREGS*WIDTH  register contents; Rn at [n*WIDTH +: WIDTH], to mux inputs 0–15
- bus_sel  out  5  registered bus-mux select
- src_valid  out  1  registered; 1 when exactly one or more out enables were asserted
- src_conflict  out  1  sticky; set when two or more out enables asserted in one cycle

## Operation
- Register write: at each edge with clear_n=1, every Rn with reg_in[n]=1 loads bus_in. Multiple set bits = broadcast, legal.
- Source encode: combine req = {ext_out, reg_out} (bit k = source code k).
  - req has exactly one bit k: bus_sel<=k, src_valid<=1.
  - req has ≥2 bits: bus_sel<=lowest set index, src_valid<=1, src_conflict<=1.
  - req = 0: bus_sel holds, src_valid<=0.
- src_conflict cleared only by reset.
- Same-cycle reg_in[n] and reg_out[n]: Rn captures bus_in; regs_flat shows the old value until the edge (no bypass).
- No state machine beyond the encode/hold register; regs_flat is a direct register view.

## Timing
- Reset (clear_n=0 at edge): all Rn=0, bus_sel=0, src_valid=0, src_conflict=0; reg_in ignored that cycle.
- Enable-to-select latency: out enables sampled at edge k; bus_sel/src_valid valid from edge k through edge k+1; bus mux presents selected source during cycle k+1.
- Write latency: reg_in sampled with bus_in at edge k; new Rn on regs_flat after edge k.
- Control unit therefore asserts Xout in step Ti and Yin in step Ti+1 for an X→Y transfer.
- Reset mid-transfer: state cleared that edge; next cycle src_valid=0, bus_sel=0.

## Configuration
- BUS_R0_ZERO_EN defined: ba_out registered alongside bus_sel; while the registered ba_out=1, R0 slice of regs_flat reads 0 (R0 contents unaffected). Used for base-address addressing with R0.
- Undefined: ba_out ignored; R0 slice always shows R0 contents; no extra flop.

## Structure
- Shared package: WIDTH default, source-code constants (SRC_R0=0 … SRC_R15=15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_C=23, 24–31 reserved).
- One sub-module: bus_encoder32 (combinational 32→5 lowest-index encoder with any/multi outputs); registers and sticky flag stay in bus_regfile.

## Test plan
- Reset: drive all enables 1, clear_n=0 one edge -> all Rn=0, bus_sel=0, src_valid=0, src_conflict=0.
- Load/broadcast: bus_in=0xDEADBEEF, reg_in=0x0024 one edge -> R2=R5=0xDEADBEEF, others 0.
- Encode: reg_out=0x0008 at edge k -> bus_sel=3, src_valid=1 after edge k; next cycle enables 0 -> bus_sel stays 3, src_valid=0.
- External source: ext_out=0x0010 -> bus_sel=20 (PC); ext_out=0x8000 -> bus_sel=31.
- Conflict: reg_out=0x0006 -> bus_sel=1, src_conflict=1; later single enables keep src_conflict=1 until clear_n=0.
- R0 gating (BUS_R0_ZERO_EN): R0=0x12345678, ba_out=1 at edge k -> R0 slice reads 0 after edge k; ba_out=0 -> 0x12345678; macro undefined -> always 0x12345678.
